// File: rtl/bp_l15_resp_encoder.sv
`default_nettype none
// ============================================================================
// Module  : bp_l15_resp_encoder
// Purpose : Turns L1.5 return packets into a 64-bit valid/ready memory
//           response stream for the BP core. One packet is captured at a
//           time. Instruction fills are split into two beats. Evictions,
//           interrupts and unknown return types produce no beats.
// Ports   : clk_i, reset_i                 - clock, sync active-high reset
//           l15_transducer_*                - L1.5 return packet (val/type/data)
//           transducer_l15_req_ack          - combinational packet ack
//           mem_resp_v_o / mem_resp_ready_i - response beat handshake
//           mem_resp_type_o/_data_o/_last_o - response beat payload
//           irq_o                           - one-cycle interrupt pulse
//           drop_cnt_o                      - saturating dropped-packet count
// Revision: 1.0 - initial release
// ============================================================================
module bp_l15_resp_encoder #(
    parameter int drop_cnt_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        l15_transducer_val,
    input  logic [3:0]                  l15_transducer_returntype,
    input  logic [63:0]                 l15_transducer_data_0,
    input  logic [63:0]                 l15_transducer_data_1,
    output logic                        transducer_l15_req_ack,
    output logic                        mem_resp_v_o,
    input  logic                        mem_resp_ready_i,
    output logic [1:0]                  mem_resp_type_o,
    output logic [63:0]                 mem_resp_data_o,
    output logic                        mem_resp_last_o,
    output logic                        irq_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam logic [1:0] RESP_LOAD  = 2'd0;
    localparam logic [1:0] RESP_IFILL = 2'd1;
    localparam logic [1:0] RESP_STACK = 2'd2;
    localparam logic [1:0] RESP_AMO   = 2'd3;

    localparam logic [drop_cnt_width_p-1:0] DROP_ONE =
        {{(drop_cnt_width_p-1){1'b0}}, 1'b1};

    state_t                      state;
    state_t                      next_state;
    logic [1:0]                  resp_type_q;
    logic [63:0]                 data0_q;
    logic [63:0]                 data1_q;
    logic                        irq_q;
    logic [drop_cnt_width_p-1:0] drop_cnt_q;

    // Decode of the incoming return type
    logic       in_is_resp;
    logic       in_is_irq;
    logic [1:0] in_resp_type;
    logic       handshake;

    always_comb begin
        in_is_resp   = 1'b0;
        in_is_irq    = 1'b0;
        in_resp_type = RESP_LOAD;
        case (l15_transducer_returntype)
            4'h0: begin in_is_resp = 1'b1; in_resp_type = RESP_LOAD;  end
            4'h1: begin in_is_resp = 1'b1; in_resp_type = RESP_IFILL; end
            4'h4: begin in_is_resp = 1'b1; in_resp_type = RESP_STACK; end
            4'hE: begin in_is_resp = 1'b1; in_resp_type = RESP_AMO;   end
            4'h7: in_is_irq = 1'b1;
            default: ;
        endcase
    end

    // Packets are only taken in IDLE; reset masks the ack so a packet held
    // across reset is consumed only once reset is released.
    assign transducer_l15_req_ack = l15_transducer_val & (state == IDLE) & ~reset_i;
    assign handshake              = mem_resp_v_o & mem_resp_ready_i;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (transducer_l15_req_ack && in_is_resp) next_state = BEAT0;
            BEAT0: if (handshake) next_state = (resp_type_q == RESP_IFILL) ? BEAT1 : IDLE;
            BEAT1: if (handshake) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            resp_type_q <= 2'd0;
            data0_q     <= 64'd0;
            data1_q     <= 64'd0;
            irq_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state <= next_state;
            irq_q <= transducer_l15_req_ack & in_is_irq;
            if (transducer_l15_req_ack) begin
                resp_type_q <= in_resp_type;
                data0_q     <= l15_transducer_data_0;
                data1_q     <= l15_transducer_data_1;
                if (!in_is_resp && !in_is_irq && (drop_cnt_q != '1))
                    drop_cnt_q <= drop_cnt_q + DROP_ONE;
            end
        end
    end

    // Beat payload is a pure function of the held state and capture
    // registers, so it stays stable while the consumer stalls.
    always_comb begin
        mem_resp_v_o    = 1'b0;
        mem_resp_type_o = 2'd0;
        mem_resp_data_o = 64'd0;
        mem_resp_last_o = 1'b0;
        case (state)
            BEAT0: begin
                mem_resp_v_o    = 1'b1;
                mem_resp_type_o = resp_type_q;
                mem_resp_data_o = (resp_type_q == RESP_STACK) ? 64'd0 : data0_q;
                mem_resp_last_o = (resp_type_q != RESP_IFILL);
            end
            BEAT1: begin
                mem_resp_v_o    = 1'b1;
                mem_resp_type_o = resp_type_q;
                mem_resp_data_o = data1_q;
                mem_resp_last_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign irq_o      = irq_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_l15_resp_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_l15_resp_encoder
// Purpose : Self-checking bench for bp_l15_resp_encoder. Each table entry
//           describes one clock cycle: the inputs driven during that cycle
//           and the outputs expected before the next rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bp_l15_resp_encoder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        val;
    logic [3:0]  rtype;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        ack;
    logic        v;
    logic        ready;
    logic [1:0]  ty;
    logic [63:0] data;
    logic        last;
    logic        irq;
    logic [7:0]  drop;

    int tests_run = 0;
    int tests_failed = 0;

    bp_l15_resp_encoder #(.drop_cnt_width_p(8)) dut (
        .clk_i                     (clk_i),
        .reset_i                   (reset_i),
        .l15_transducer_val        (val),
        .l15_transducer_returntype (rtype),
        .l15_transducer_data_0     (d0),
        .l15_transducer_data_1     (d1),
        .transducer_l15_req_ack    (ack),
        .mem_resp_v_o              (v),
        .mem_resp_ready_i          (ready),
        .mem_resp_type_o           (ty),
        .mem_resp_data_o           (data),
        .mem_resp_last_o           (last),
        .irq_o                     (irq),
        .drop_cnt_o                (drop)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        rst;
        logic        val;
        logic [3:0]  rt;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        rdy;
        logic        e_ack;
        logic        e_v;
        logic [1:0]  e_ty;
        logic [63:0] e_data;
        logic        e_last;
        logic        e_irq;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rst, logic vl, logic [3:0] rt,
                                logic [63:0] a, logic [63:0] b, logic rdy,
                                logic e_ack, logic e_v, logic [1:0] e_ty,
                                logic [63:0] e_data, logic e_last, logic e_irq,
                                logic [7:0] e_drop);
        vec_t t;
        t.name = name; t.rst = rst; t.val = vl; t.rt = rt; t.d0 = a; t.d1 = b;
        t.rdy = rdy; t.e_ack = e_ack; t.e_v = e_v; t.e_ty = e_ty;
        t.e_data = e_data; t.e_last = e_last; t.e_irq = e_irq; t.e_drop = e_drop;
        return t;
    endfunction

    // Drive one cycle's inputs at the falling edge and compare just after.
    task automatic run_vec(input vec_t t);
        @(negedge clk_i);
        reset_i = t.rst; val = t.val; rtype = t.rt; d0 = t.d0; d1 = t.d1; ready = t.rdy;
        #1;
        tests_run++;
        if (ack !== t.e_ack || v !== t.e_v || ty !== t.e_ty || data !== t.e_data ||
            last !== t.e_last || irq !== t.e_irq || drop !== t.e_drop) begin
            tests_failed++;
            $display("FAIL %s: got ack=%b v=%b ty=%0d data=%h last=%b irq=%b drop=%0d, want ack=%b v=%b ty=%0d data=%h last=%b irq=%b drop=%0d",
                     t.name, ack, v, ty, data, last, irq, drop,
                     t.e_ack, t.e_v, t.e_ty, t.e_data, t.e_last, t.e_irq, t.e_drop);
        end
    endtask

    initial begin
        reset_i = 1'b1; val = 1'b0; rtype = 4'h0; d0 = 64'd0; d1 = 64'd0; ready = 1'b0;
        repeat (2) @(posedge clk_i);

        //                 name           rst val rt     d0                      d1        rdy  ack v ty data                    last irq drop
        vecs.push_back(mk("reset",        1, 1, 4'h0, 64'h1,                  64'h0,    1,   0, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("load_acc",     0, 1, 4'h0, 64'hDEADBEEF_01234567,  64'h0,    1,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("load_beat",    0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 1, 0, 64'hDEADBEEF_01234567, 1, 0, 0));
        vecs.push_back(mk("load_done",    0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("ifill_acc",    0, 1, 4'h1, 64'h1111,               64'h2222, 0,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("ifill_b0_s1",  0, 1, 4'h0, 64'hAAAA,               64'h0,    0,   0, 1, 1, 64'h1111,              0, 0, 0));
        vecs.push_back(mk("ifill_b0_s2",  0, 1, 4'h0, 64'hAAAA,               64'h0,    0,   0, 1, 1, 64'h1111,              0, 0, 0));
        vecs.push_back(mk("ifill_b0_s3",  0, 1, 4'h0, 64'hAAAA,               64'h0,    0,   0, 1, 1, 64'h1111,              0, 0, 0));
        vecs.push_back(mk("ifill_b0_hs",  0, 1, 4'h0, 64'hAAAA,               64'h0,    1,   0, 1, 1, 64'h1111,              0, 0, 0));
        vecs.push_back(mk("ifill_b1_hs",  0, 1, 4'h0, 64'hAAAA,               64'h0,    1,   0, 1, 1, 64'h2222,              1, 0, 0));
        vecs.push_back(mk("held_acc",     0, 1, 4'h0, 64'hAAAA,               64'h0,    1,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("held_beat",    0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 1, 0, 64'hAAAA,              1, 0, 0));
        vecs.push_back(mk("stack_acc",    0, 1, 4'h4, 64'hFFFF,               64'h0,    1,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("stack_beat",   0, 1, 4'hE, 64'h5,                  64'h0,    1,   0, 1, 2, 64'h0,                 1, 0, 0));
        vecs.push_back(mk("amo_acc",      0, 1, 4'hE, 64'h5,                  64'h0,    1,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("amo_beat",     0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 1, 3, 64'h5,                 1, 0, 0));
        vecs.push_back(mk("amo_done",     0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("int_acc",      0, 1, 4'h7, 64'h0,                  64'h0,    1,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("int_pulse",    0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 0, 0, 64'h0,                 0, 1, 0));
        vecs.push_back(mk("int_end",      0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("evict_acc",    0, 1, 4'h3, 64'h0,                  64'h0,    1,   1, 0, 0, 64'h0,                 0, 0, 0));
        vecs.push_back(mk("evict_cnt",    0, 0, 4'h0, 64'h0,                  64'h0,    1,   0, 0, 0, 64'h0,                 0, 0, 1));
        vecs.push_back(mk("unk_acc",      0, 1, 4'h9, 64'h0,                  64'h0,    0,   1, 0, 0, 64'h0,                 0, 0, 1));
        vecs.push_back(mk("unk_cnt",      0, 0, 4'h0, 64'h0,                  64'h0,    0,   0, 0, 0, 64'h0,                 0, 0, 2));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back evictions: acked every cycle, count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            int exp_cnt;
            exp_cnt = (2 + i > 255) ? 255 : 2 + i;
            run_vec(mk("evict_burst", 0, 1, 4'h3, 64'h0, 64'h0, 1,
                       1, 0, 0, 64'h0, 0, 0, 8'(exp_cnt)));
        end
        run_vec(mk("evict_sat",     0, 0, 4'h0, 64'h0,  64'h0,  1,  0, 0, 0, 64'h0,  0, 0, 255));

        // Reset arriving during the second ifill beat.
        run_vec(mk("rst_ifill_acc", 0, 1, 4'h1, 64'h77, 64'h88, 1,  1, 0, 0, 64'h0,  0, 0, 255));
        run_vec(mk("rst_ifill_b0",  0, 0, 4'h0, 64'h0,  64'h0,  1,  0, 1, 1, 64'h77, 0, 0, 255));
        run_vec(mk("rst_ifill_b1",  0, 1, 4'h0, 64'h99, 64'h0,  0,  0, 1, 1, 64'h88, 1, 0, 255));
        run_vec(mk("rst_mask_ack",  1, 1, 4'h0, 64'h99, 64'h0,  0,  0, 1, 1, 64'h88, 1, 0, 255));
        run_vec(mk("rst_after",     0, 1, 4'h0, 64'h99, 64'h0,  1,  1, 0, 0, 64'h0,  0, 0, 0));
        run_vec(mk("rst_held_beat", 0, 0, 4'h0, 64'h0,  64'h0,  1,  0, 1, 0, 64'h99, 1, 0, 0));
        run_vec(mk("rst_idle",      0, 0, 4'h0, 64'h0,  64'h0,  1,  0, 0, 0, 64'h0,  0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_l15_resp_encoder.md
Name: bp_l15_resp_encoder

Overview:
- Converts L1.5 return packets into a 64-bit valid/ready memory-response stream for the BP core.
- Sits beside the BP->L1.5 request path in the L1.5 tile interface and handles the return direction only.
- Captures one packet at a time and serializes instruction-fill returns into two beats.
- Filters eviction, interrupt and unknown return types, which produce no response beats.

Parameters:
drop_cnt_width_p, 8, width of the saturating counter of dropped (non-response) packets

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_i  in  1  synchronous, active-high reset
l15_transducer_val  in  1  L1.5 return packet valid; held by L1.5 until acked
l15_transducer_returntype  in  4  return type: 0x0 LOAD_RET, 0x1 IFILL_RET, 0x3 EVICT_REQ, 0x4 ST_ACK, 0x7 INT_RET, 0xE ATOMIC_RET
l15_transducer_data_0  in  64  return data word 0
l15_transducer_data_1  in  64  return data word 1
transducer_l15_req_ack  out  1  combinational ack; packet consumed in this cycle
mem_resp_v_o  out  1  response beat valid
mem_resp_ready_i  in  1  BP consumer ready
mem_resp_type_o  out  2  response type: 0 load, 1 ifill, 2 store ack, 3 amo
mem_resp_data_o  out  64  beat data
mem_resp_last_o  out  1  final beat of the response
irq_o  out  1  one-cycle interrupt pulse
drop_cnt_o  out  drop_cnt_width_p  saturating count of dropped packets

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1.
- Reset:
  - state=IDLE; capture registers=0.
  - mem_resp_v_o=0, mem_resp_type_o=0, mem_resp_data_o=0, mem_resp_last_o=0, irq_o=0, drop_cnt_o=0.
  - req_ack is forced to 0 while reset_i=1.
  - Reset mid-transfer abandons any pending beats; no further ack or beat is produced for that packet.
- Ack: req_ack = val & (state==IDLE) & ~reset_i. No packet is accepted in BEAT0 or BEAT1.
- On accept, type and data_0/data_1 are registered.
- LOAD_RET, ATOMIC_RET, ST_ACK:
  - Next state is BEAT0; mem_resp_v_o=1 the cycle after accept (latency 1).
  - Data: data_0 for load and atomic; 0 for ST_ACK.
  - last=1.
- IFILL_RET:
  - BEAT0 presents data_0 with last=0.
  - On handshake (v_o & ready_i) go to BEAT1, which presents data_1 with last=1.
- Transitions:
  - BEAT0: handshake with a non-ifill type -> IDLE; handshake with ifill -> BEAT1.
  - BEAT1: handshake -> IDLE.
  - No handshake: hold the current state.
- Valid/ready rule: while v_o=1 and ready_i=0, type, data and last hold stable. v_o never retracts before the handshake.
- Throughput: a new packet is accepted no earlier than the cycle after the final beat's handshake. Single-beat packets cost 2 cycles minimum; ifill costs 3.
- INT_RET: acked in IDLE; no beats; state stays IDLE; irq_o=1 for exactly the cycle after accept. Not counted as dropped.
- EVICT_REQ and any unlisted returntype: acked in IDLE; no beats; drop_cnt_o increments the cycle after accept.
- drop_cnt_o saturates at all-ones and does not wrap.
- Back-to-back filtered packets: acked on consecutive cycles; one increment or irq pulse per packet.
- ready_i asserted while v_o=0 has no effect.

Test Plan:
- Reset, then LOAD_RET with data_0=0xDEADBEEF_01234567 and ready=1 -> req_ack the same cycle; the next cycle gives v_o=1, type=0, data=0xDEADBEEF_01234567, last=1; the cycle after gives v_o=0.
- IFILL_RET with data_0=0x1111, data_1=0x2222 and ready held 0 for 3 cycles -> beat0 (0x1111, last=0) stays stable for 3 cycles; after ready=1, beat1 (0x2222, last=1); a second val held during the transfer is not acked until the FSM returns to IDLE.
- ST_ACK followed immediately by ATOMIC_RET with data_0=0x5 -> store-ack beat (type=2, data=0, last=1), then the ATOMIC_RET is acked the cycle after that handshake, then an amo beat (type=3, data=0x5).
- 300 consecutive EVICT_REQ packets -> all acked on consecutive cycles, no v_o, drop_cnt_o saturates at 255.
- INT_RET -> ack, irq_o high for exactly 1 cycle, drop_cnt_o unchanged, no beats.
- Assert reset_i during BEAT1 of an IFILL_RET -> v_o=0 and state IDLE the next cycle; a packet held during reset is acked only after reset deasserts.
